siren_zone_annunciator: RTL and testbench
=========================================

// Module: siren_zone_annunciator
// PURPOSE
//  Shares one physical siren and one zone display among N_ZONES siren controllers, each guarding one zone.
//  Latches every zone's alarm request and round-robins the latched zones onto the shared siren.
//  Each zone gets a fixed dwell slot with an on/off cadence, so the operator can tell which zone is sounding.
//  Sits between the per-zone siren instances (their alarm_siren outputs) and the siren driver / front panel.
// PARAMETERS
//  N_ZONES    4   number of zone request inputs (>=2)
//  DWELL      16  ENA ticks per zone slot (>=2)
//  ON_TICKS   4   ENA ticks siren_drive is high per cadence period (>=1)
//  OFF_TICKS  4   ENA ticks siren_drive is low per cadence period (>=1)
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  reset        in   1        asynchronous, active-low reset
//  ENA          in   1        clock-enable tick; gates FSM, dwell and cadence counters only
//  alarm_req    in   N_ZONES  level alarm request per zone, bit i = zone i
//  ack          in   1        operator acknowledge, sampled every clk
//  mute         in   1        forces siren_drive low; scheduling continues
//  siren_drive  out  1        shared siren output
//  active_zone  out  clog2(N) zone currently owning the siren (valid when zone_valid=1)
//  zone_valid   out  1        1 in SOUND state
//  latched      out  N_ZONES  latched alarm flags
//  any_alarm    out  1        |latched
// BEHAVIOUR
//  Reset (reset=0, async): latched=0, state=IDLE, siren_drive=0, active_zone=0, zone_valid=0, any_alarm=0;
//   RR pointer=N_ZONES-1, so zone 0 wins the first pick. Release is synchronous to clk.
//  Latching, every clk regardless of ENA: latched[i] <= alarm_req[i] | (latched[i] & ~(ack & ~alarm_req[i])).
//   Set beats clear: ack has no effect on a zone whose request is still high in the same cycle.
//   A 1-clk request pulse is never lost. latched is visible on the clk after the request.
//  FSM, advances only on clk edges with ENA=1. Cadence and dwell counters hold when ENA=0.
//   IDLE:   zone_valid=0, siren_drive=0. If latched!=0 -> SELECT.
//   SELECT: zone_valid=0, siren_drive=0. If latched==0 -> IDLE.
//           Otherwise pick the first latched zone searching ptr+1, ptr+2, ... modulo N_ZONES,
//           including ptr itself last, so a lone zone is re-picked. Then:
//           active_zone<=pick, ptr<=pick, dwell<=DWELL-1, cadence phase=ON with count ON_TICKS-1, go SOUND.
//   SOUND:  zone_valid=1. Each ENA tick counts cadence:
//           ON for ON_TICKS ticks, then OFF for OFF_TICKS ticks, repeating, and decrements dwell.
//           Go to SELECT on the ENA tick where dwell==0, or on the first ENA tick where latched[active_zone]==0
//           (slot abandoned early).
//  siren_drive = (state==SOUND) & cadence_on & ~mute. It is derived from registers only, with no input-to-output path.
//  active_zone holds its last value outside SOUND.
//  Counter wrap: cadence counter reloads on phase change; dwell does not wrap and is reloaded only in SELECT.
//  Simultaneous: a zone latched during SOUND waits for the next SELECT; no preemption.
//  ack during SOUND that clears the active zone ends its slot at the next ENA tick.
//  Reset asserted mid-slot returns everything to reset values immediately.
// TESTING
//  T1 reset=0 8 clk, ENA=1, alarm_req=4'b0100 for 1 clk -> latched=0100 next clk;
//     SOUND zone 2 two ENA ticks later; siren_drive 4 high / 4 low x2; slot repeats while latched.
//  T2 alarm_req=4'b1001 held, ENA=1 -> slot order zone 0, 3, 0, 3, each 16 ENA ticks in SOUND, 1 tick SELECT gap.
//  T3 req[1] high, ack=1 -> latched[1] stays 1; req[1]=0 then ack 1 clk -> latched=0, next ENA tick SELECT -> IDLE,
//     siren_drive=0, any_alarm=0.
//  T4 ENA=0 for 20 clk during SOUND with a new req[3] pulse -> counters/siren frozen, latched[3]=1;
//     ENA=1 resumes the exact remaining dwell/cadence.
//  T5 mute=1 through two slots of zones 0,2 -> siren_drive=0 throughout; active_zone sequence 0, 2 unchanged.
//  T6 reset=0 mid-SOUND, asynchronous to clk -> all outputs 0 before the next edge;
//     after release with req 4'b0011 the first pick is zone 0.

Source files
------------

// File: rtl/siren_zone_annunciator.sv
// Shared siren / zone display arbiter for N_ZONES siren controllers.
// Latches zone alarms and round-robins them onto one cadenced siren.
module siren_zone_annunciator #(
  parameter int N_ZONES   = 4,
  parameter int DWELL     = 16,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ENA,
  input  logic [N_ZONES-1:0]         alarm_req,
  input  logic                       ack,
  input  logic                       mute,
  output logic                       siren_drive,
  output logic [$clog2(N_ZONES)-1:0] active_zone,
  output logic                       zone_valid,
  output logic [N_ZONES-1:0]         latched,
  output logic                       any_alarm
);

  localparam int ZW   = $clog2(N_ZONES);
  localparam int DW   = $clog2(DWELL);
  localparam int CMAX = (ON_TICKS > OFF_TICKS) ?
                        ON_TICKS : OFF_TICKS;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_SOUND
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [N_ZONES-1:0]  r_latched;
  logic [ZW-1:0]       r_zone;
  logic [ZW-1:0]       w_zone_nx;
  logic [ZW-1:0]       r_ptr;
  logic [ZW-1:0]       w_ptr_nx;
  logic [ZW-1:0]       w_pick;
  logic [DW-1:0]       r_dwell;
  logic [DW-1:0]       w_dwell_nx;
  logic                r_cad_on;
  logic                w_cad_on_nx;
  logic [CW-1:0]       r_cad_cnt;
  logic [CW-1:0]       w_cad_cnt_nx;
  logic                r_mute;

  // Set beats clear: ack only drops zones whose request is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_latched <= '0;
      r_mute    <= 1'b0;
    end else begin
      r_latched <= alarm_req |
                   (r_latched & ~({N_ZONES{ack}} & ~alarm_req));
      r_mute    <= mute;
    end
  end

  // Lowest offset from ptr+1 wins; ptr itself is tried last.
  always_comb begin
    w_pick = r_ptr;
    for (int j = N_ZONES; j >= 1; j--) begin
      if (r_latched[(int'(r_ptr) + j) % N_ZONES]) begin
        w_pick = ZW'((int'(r_ptr) + j) % N_ZONES);
      end
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_zone_nx    = r_zone;
    w_ptr_nx     = r_ptr;
    w_dwell_nx   = r_dwell;
    w_cad_on_nx  = r_cad_on;
    w_cad_cnt_nx = r_cad_cnt;
    if (ENA) begin
      unique case (r_state)
        S_IDLE: begin
          if (|r_latched) w_state_nx = S_SELECT;
        end
        S_SELECT: begin
          if (~|r_latched) begin
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx   = S_SOUND;
            w_zone_nx    = w_pick;
            w_ptr_nx     = w_pick;
            w_dwell_nx   = DW'(DWELL - 1);
            w_cad_on_nx  = 1'b1;
            w_cad_cnt_nx = CW'(ON_TICKS - 1);
          end
        end
        S_SOUND: begin
          if (r_dwell == '0 || !r_latched[r_zone]) begin
            w_state_nx = S_SELECT;
          end else begin
            w_dwell_nx = r_dwell - DW'(1);
            if (r_cad_cnt == '0) begin
              w_cad_on_nx  = ~r_cad_on;
              w_cad_cnt_nx = r_cad_on ?
                             CW'(OFF_TICKS - 1) :
                             CW'(ON_TICKS - 1);
            end else begin
              w_cad_cnt_nx = r_cad_cnt - CW'(1);
            end
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_zone    <= '0;
      r_ptr     <= ZW'(N_ZONES - 1);
      r_dwell   <= '0;
      r_cad_on  <= 1'b0;
      r_cad_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_zone    <= w_zone_nx;
      r_ptr     <= w_ptr_nx;
      r_dwell   <= w_dwell_nx;
      r_cad_on  <= w_cad_on_nx;
      r_cad_cnt <= w_cad_cnt_nx;
    end
  end

  assign zone_valid  = (r_state == S_SOUND);
  assign siren_drive = zone_valid & r_cad_on & ~r_mute;
  assign active_zone = r_zone;
  assign latched     = r_latched;
  assign any_alarm   = |r_latched;

endmodule

// File: tb/tb_siren_zone_annunciator.sv
// Bench for siren_zone_annunciator: directed scenarios plus
// randomized traffic against a slot/tick-count reference model.
module tb_siren_zone_annunciator;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int ON  = 4;
  localparam int OFF = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       ENA   = 1'b0;
  logic       ack   = 1'b0;
  logic       mute  = 1'b0;
  logic [3:0] req   = 4'b0;
  logic       siren;
  logic       zv;
  logic       any;
  logic [1:0] az;
  logic [3:0] lat;

  always #5 clk = ~clk;

  siren_zone_annunciator #(
    .N_ZONES(N), .DWELL(DW),
    .ON_TICKS(ON), .OFF_TICKS(OFF)
  ) dut (
    .clk(clk), .reset(reset), .ENA(ENA),
    .alarm_req(req), .ack(ack), .mute(mute),
    .siren_drive(siren), .active_zone(az),
    .zone_valid(zv), .latched(lat),
    .any_alarm(any)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 select, 2 sounding; k = ENA ticks
  // spent in the current slot.
  int         m_mode = 0;
  int         m_zone = 0;
  int         m_ptr  = N - 1;
  int         m_k    = 0;
  logic [3:0] m_L    = 4'b0;
  logic       m_mute = 1'b0;

  task automatic m_reset();
    m_mode = 0; m_zone = 0; m_ptr = N - 1;
    m_k = 0; m_L = 4'b0; m_mute = 1'b0;
  endtask

  always @(negedge reset) m_reset();

  always @(posedge clk) begin
    logic [3:0] old;
    int pick;
    if (!reset) begin
      m_reset();
    end else begin
      old    = m_L;
      m_L    = req | (old & ~(ack ? ~req : 4'b0));
      m_mute = mute;
      if (ENA) begin
        if (m_mode == 0) begin
          if (old != 0) m_mode = 1;
        end else if (m_mode == 1) begin
          if (old == 0) m_mode = 0;
          else begin
            pick = -1;
            for (int j = 1; j <= N; j++)
              if (pick < 0 && old[(m_ptr + j) % N])
                pick = (m_ptr + j) % N;
            m_zone = pick; m_ptr = pick;
            m_k = 0; m_mode = 2;
          end
        end else begin
          if (m_k == DW - 1 || !old[m_zone]) m_mode = 1;
          else m_k++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic e_snd;
    e_snd = (m_mode == 2);
    chk("m_zv", zv, e_snd);
    chk("m_siren", siren,
        e_snd && (m_k % (ON + OFF)) < ON && !m_mute);
    chk("m_zone", az, m_zone[1:0]);
    chk("m_lat", lat, m_L);
    chk("m_any", any, m_L != 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; req = 4'b0; ack = 1'b0;
    mute = 1'b0; ENA = 1'b1;
    tick(2);
    reset = 1'b1;
  endtask

  task automatic wait_zv(input logic v, input int lim);
    int n = 0;
    while (zv !== v && n < lim) begin
      tick();
      n++;
    end
    if (zv !== v) chk("wait_zv_timeout", zv, v);
  endtask

  task automatic run_len(input logic v, input int lim,
                         output int n);
    n = 0;
    while (zv === v && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic clear_all();
    req = 4'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(3);
  endtask

  initial begin
    logic [15:0] s;
    logic [1:0]  zs [4];
    int          n;
    int          got;
    logic        s0;
    logic        prev;
    logic        sor;

    // T1
    tick(8);
    chk("t1_rst_zv", zv, 0);
    chk("t1_rst_lat", lat, 0);
    reset = 1'b1; ENA = 1'b1;
    tick();
    req = 4'b0100;
    tick();
    req = 4'b0;
    chk("t1_lat", lat, 4'b0100);
    tick(2);
    chk("t1_zv", zv, 1);
    chk("t1_zone", az, 2);
    for (int i = 0; i < 16; i++) begin
      s[i] = siren;
      tick();
    end
    chk("t1_cadence", s, 16'h0F0F);
    chk("t1_gap", zv, 0);
    tick();
    chk("t1_repeat_zv", zv, 1);
    chk("t1_repeat_zone", az, 2);
    clear_all();
    chk("t1_clr_zv", zv, 0);

    // T2
    do_reset();
    req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_zv(1'b1, 10);
      zs[k] = az;
      run_len(1'b1, 40, n);
      chk("t2_slot_len", n, 16);
      if (k < 3) begin
        run_len(1'b0, 10, n);
        chk("t2_gap_len", n, 1);
      end
    end
    chk("t2_order", {zs[0], zs[1], zs[2], zs[3]},
        8'b00_11_00_11);
    clear_all();

    // T3
    req = 4'b0010; ack = 1'b1;
    tick(2);
    chk("t3_set_wins", lat[1], 1);
    req = 4'b0; ack = 1'b0;
    tick();
    chk("t3_hold", lat, 4'b0010);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t3_cleared", lat, 0);
    tick(4);
    chk("t3_zv", zv, 0);
    chk("t3_siren", siren, 0);
    chk("t3_any", any, 0);

    // T4
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0;
    wait_zv(1'b1, 10);
    tick(5);
    s0 = siren;
    ENA = 1'b0;
    req = 4'b1000;
    tick();
    req = 4'b0;
    tick(19);
    chk("t4_siren_frozen", siren, s0);
    chk("t4_zv_frozen", zv, 1);
    chk("t4_zone_frozen", az, 0);
    chk("t4_lat", lat, 4'b1001);
    ENA = 1'b1;
    run_len(1'b1, 40, n);
    chk("t4_remaining", n, 11);
    wait_zv(1'b1, 10);
    chk("t4_next_zone", az, 3);
    clear_all();

    // T5
    do_reset();
    mute = 1'b1;
    req = 4'b0101;
    sor = 1'b0; got = 0; prev = zv;
    for (int i = 0; i < 40; i++) begin
      sor |= siren;
      if (zv && !prev && got < 2) begin
        zs[got] = az;
        got++;
      end
      prev = zv;
      tick();
    end
    chk("t5_muted", sor, 0);
    chk("t5_slots", got, 2);
    chk("t5_order", {zs[0], zs[1]}, 4'b00_10);
    mute = 1'b0;
    clear_all();

    // T6
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0;
    wait_zv(1'b1, 10);
    tick(3);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_siren", siren, 0);
    chk("t6_zv", zv, 0);
    chk("t6_zone", az, 0);
    chk("t6_lat", lat, 0);
    chk("t6_any", any, 0);
    req = 4'b0011;
    tick(3);
    reset = 1'b1;
    wait_zv(1'b1, 10);
    chk("t6_first_pick", az, 0);
    clear_all();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ENA = ($urandom % 4) != 0;
      n = $urandom % 100;
      if (n < 10)
        req = 4'($urandom_range(0, 15) &
                 $urandom_range(0, 15));
      else if (n < 40)
        req = 4'b0;
      ack = ($urandom % 10) == 0;
      if ($urandom % 16 == 0) mute = ~mute;
      if ($urandom % 700 == 0) begin
        #2 reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
